// File: rtl/axi4_read_slave_responder.sv
// rtl/axi4_read_slave_responder.sv - AXI4 read slave answering bursts with address-pattern data
// Queues AR requests, waits RD_LATENCY cycles, then streams one whole burst at a time.

module axi4_read_slave_responder #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 64,
   parameter int          ID_WIDTH   = 4,
   parameter int          FIFO_DEPTH = 4,
   parameter int          RD_LATENCY = 2,
   parameter logic [31:0] MEM_SIZE   = 32'h0001_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [7:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [ID_WIDTH-1:0]   rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REP   = DATA_WIDTH / ADDR_WIDTH;
   localparam int ENT_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
   localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   state_t state, state_next;

   logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  beat_fire;

   logic [ID_WIDTH-1:0]   h_id;
   logic [ADDR_WIDTH-1:0] h_addr;
   logic [7:0]            h_len;
   logic [2:0]            h_size;
   logic [1:0]            h_burst;
   logic [ADDR_WIDTH-1:0] h_cont;
   logic [ADDR_WIDTH-1:0] h_lower;
   logic [1:0]            h_resp;

   logic [3:0]            lat_cnt;
   logic [7:0]            beat_cnt;
   logic [ID_WIDTH-1:0]   act_id;
   logic [7:0]            act_len;
   logic [2:0]            act_size;
   logic [1:0]            act_burst;
   logic [1:0]            act_resp;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] wrap_lower;
   logic [ADDR_WIDTH-1:0] wrap_end;

   logic [ADDR_WIDTH-1:0] nbytes;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  last_beat;

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign arready    = !fifo_full;
   assign push       = arvalid && arready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {arid, araddr, arlen, arsize, arburst};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign {h_id, h_addr, h_len, h_size, h_burst} = fifo_mem[rd_ptr];

   // Wrap container is (len+1) beats of 2^size bytes; only meaningful for WRAP bursts.
   assign h_cont  = (ADDR_WIDTH'(h_len) + ADDR_WIDTH'(1)) << h_size;
   assign h_lower = h_addr & ~(h_cont - ADDR_WIDTH'(1));
   assign h_resp  = (h_addr >= MEM_LIMIT) ? 2'b11 :
                    (h_burst == 2'd3)     ? 2'b10 : 2'b00;

   assign nbytes    = ADDR_WIDTH'(1) << act_size;
   assign incr_addr = (cur_addr & ~(nbytes - ADDR_WIDTH'(1))) + nbytes;
   assign last_beat = (beat_cnt == act_len);

   always_comb begin
      next_addr = incr_addr;
      case (act_burst)
         2'd0:    next_addr = cur_addr;
         2'd2:    next_addr = (incr_addr == wrap_end) ? wrap_lower : incr_addr;
         default: next_addr = incr_addr;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      beat_fire  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = (RD_LATENCY > 0) ? S_WAIT : S_BURST;
            end
         end
         S_WAIT: begin
            if (lat_cnt <= 4'd1) state_next = S_BURST;
         end
         S_BURST: begin
            if (rready) begin
               beat_fire = 1'b1;
               if (last_beat) state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt    <= '0;
         beat_cnt   <= '0;
         act_id     <= '0;
         act_len    <= '0;
         act_size   <= '0;
         act_burst  <= '0;
         act_resp   <= '0;
         cur_addr   <= '0;
         wrap_lower <= '0;
         wrap_end   <= '0;
      end else begin
         if (pop) begin
            lat_cnt    <= 4'(RD_LATENCY);
            beat_cnt   <= '0;
            act_id     <= h_id;
            act_len    <= h_len;
            act_size   <= h_size;
            act_burst  <= h_burst;
            act_resp   <= h_resp;
            cur_addr   <= h_addr;
            wrap_lower <= h_lower;
            wrap_end   <= h_lower + h_cont;
         end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
         if (beat_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= next_addr;
         end
      end
   end

   // Payload is forced to zero outside BURST so reset and idle read all-zero.
   assign rvalid = (state == S_BURST);
   assign rid    = rvalid ? act_id : '0;
   assign rresp  = rvalid ? act_resp : 2'b00;
   assign rlast  = rvalid && last_beat;
   assign rdata  = (rvalid && act_resp == 2'b00) ? {REP{cur_addr}} : '0;

endmodule

// File: tb/tb_axi4_read_slave_responder.sv
// tb/tb_axi4_read_slave_responder.sv - randomized bench with burst-level reference model
// Directed literal bursts pin the model; random traffic is scored beat by beat.

module tb_axi4_read_slave_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   axi4_read_slave_responder dut (
      .clk     (clk),
      .rst     (rst),
      .arvalid (arvalid),
      .arready (arready),
      .arid    (arid),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .rvalid  (rvalid),
      .rready  (rready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    n_pass  = 0;
   int    n_total = 0;
   int    cyc     = 0;
   int    rr_mode = 0;

   task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Every beat of a burst is derived from the AR fields alone.
   function automatic void model_push(input logic [3:0] id, input logic [31:0] a,
                                      input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      beat_t       b;
      logic [31:0] nb, aligned, cont, lower, addr;
      logic [1:0]  resp;
      nb      = 32'd1 << size;
      aligned = a & ~(nb - 32'd1);
      cont    = (32'(len) + 32'd1) * nb;
      lower   = a & ~(cont - 32'd1);
      resp    = (a >= 32'h0001_0000) ? 2'b11 : (burst == 2'd3) ? 2'b10 : 2'b00;
      for (int n = 0; n <= int'(len); n++) begin
         if (n == 0 || burst == 2'd0) addr = a;
         else if (burst == 2'd2)      addr = lower + ((aligned - lower + 32'(n) * nb) % cont);
         else                         addr = aligned + 32'(n) * nb;
         b.id   = id;
         b.resp = resp;
         b.data = (resp == 2'b00) ? {addr, addr} : 64'd0;
         b.last = (n == int'(len));
         exp_q.push_back(b);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
         0:       rready = 1'b1;
         1:       rready = ($urandom_range(0, 9) < 7);
         default: rready = 1'b0;
      endcase
   end

   // Scoreboard: every rvalid cycle must show the oldest outstanding beat.
   initial begin
      bit prev_last_fire;
      prev_last_fire = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            prev_last_fire = 1'b0;
         end else begin
            if (prev_last_fire) check("idle_gap_rvalid", 72'(rvalid), 72'(0));
            prev_last_fire = 1'b0;
            if (rvalid) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_beat: rvalid=1 rid=%0d with no beat outstanding", rid);
               end else begin
                  check("r_rid",   72'(rid),   72'(exp_q[0].id));
                  check("r_rdata", 72'(rdata), 72'(exp_q[0].data));
                  check("r_rresp", 72'(rresp), 72'(exp_q[0].resp));
                  check("r_rlast", 72'(rlast), 72'(exp_q[0].last));
                  if (rready) begin
                     prev_last_fire = rlast;
                     void'(exp_q.pop_front());
                  end
               end
            end
            if (arvalid && arready) model_push(arid, araddr, arlen, arsize, arburst);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
      bit ok;
      ok      = 1'b0;
      arid    = id;
      araddr  = a;
      arlen   = len;
      arsize  = size;
      arburst = burst;
      arvalid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (arready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      hs_cyc = cyc;
      if (!ok) begin
         n_total++;
         $display("FAIL ar_accept_timeout: id %0d not accepted within 300 cycles", id);
      end
      @(posedge clk);
      #1;
      arvalid = 1'b0;
   endtask

   task automatic expect_beat(input string name, input logic [3:0] id, input logic [63:0] data,
                              input logic [1:0] resp, input logic last, output int at_cyc);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rvalid && rready) begin
            ok = 1'b1;
            break;
         end
      end
      at_cyc = cyc;
      if (ok) begin
         check(name, {rid, rdata, rresp, rlast, 1'b0}, {id, data, resp, last, 1'b0});
      end else begin
         n_total++;
         $display("FAIL %s_timeout: no beat within 300 cycles", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rvalid) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 72'(exp_q.size()), 72'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          hs, t, t0, seen;
      logic [7:0]  wl [4];
      logic [3:0]  rid_r;
      logic [31:0] a_r;
      logic [7:0]  len_r;
      logic [2:0]  size_r;
      logic [1:0]  burst_r;
      int          r;
      wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

      // Reset state
      #12;
      check("reset_outputs", {rvalid, rlast, rid, rdata, rresp}, 72'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_arready", 72'(arready), 72'(1));
      tick(1);

      // INCR with latency
      send_ar(4'd5, 32'h100, 8'd3, 3'd3, 2'd1, hs);
      expect_beat("incr_b0", 4'd5, 64'h00000100_00000100, 2'b00, 1'b0, t0);
      check("incr_first_latency", 72'(t0 - hs), 72'(4));
      expect_beat("incr_b1", 4'd5, 64'h00000108_00000108, 2'b00, 1'b0, t);
      expect_beat("incr_b2", 4'd5, 64'h00000110_00000110, 2'b00, 1'b0, t);
      expect_beat("incr_b3", 4'd5, 64'h00000118_00000118, 2'b00, 1'b1, t);

      // WRAP
      send_ar(4'd2, 32'h38, 8'd3, 3'd3, 2'd2, hs);
      expect_beat("wrap_b0", 4'd2, 64'h00000038_00000038, 2'b00, 1'b0, t);
      expect_beat("wrap_b1", 4'd2, 64'h00000020_00000020, 2'b00, 1'b0, t);
      expect_beat("wrap_b2", 4'd2, 64'h00000028_00000028, 2'b00, 1'b0, t);
      expect_beat("wrap_b3", 4'd2, 64'h00000030_00000030, 2'b00, 1'b1, t);

      // FIXED
      send_ar(4'd3, 32'h44, 8'd2, 3'd2, 2'd0, hs);
      expect_beat("fixed_b0", 4'd3, 64'h00000044_00000044, 2'b00, 1'b0, t);
      expect_beat("fixed_b1", 4'd3, 64'h00000044_00000044, 2'b00, 1'b0, t);
      expect_beat("fixed_b2", 4'd3, 64'h00000044_00000044, 2'b00, 1'b1, t);

      // Error responses
      send_ar(4'd4, 32'h0002_0000, 8'd0, 3'd3, 2'd1, hs);
      expect_beat("decerr", 4'd4, 64'd0, 2'b11, 1'b1, t);
      send_ar(4'd6, 32'h0, 8'd0, 3'd3, 2'd3, hs);
      expect_beat("slverr", 4'd6, 64'd0, 2'b10, 1'b1, t);
      send_ar(4'd7, 32'h0002_0000, 8'd0, 3'd3, 2'd3, hs);
      expect_beat("decerr_priority", 4'd7, 64'd0, 2'b11, 1'b1, t);
      wait_drain("drain_directed");

      // Backpressure: active burst stalls, FIFO fills with four, fifth waits for a pop
      rr_mode = 2;
      tick(2);
      send_ar(4'd1, 32'h1000, 8'd1, 3'd3, 2'd1, hs);
      for (int i = 2; i <= 5; i++) send_ar(4'(i), 32'h2000 + 32'(i) * 32'h40, 8'd1, 3'd3, 2'd1, hs);
      arid    = 4'd6;
      araddr  = 32'h3000;
      arlen   = 8'd0;
      arsize  = 3'd3;
      arburst = 2'd1;
      arvalid = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (arready) seen++;
      end
      check("bp_arready_full", 72'(seen), 72'(0));
      tick(1);
      rr_mode = 0;
      send_ar(4'd6, 32'h3000, 8'd0, 3'd3, 2'd1, hs);
      wait_drain("drain_backpressure");

      // Reset during beat 1 of 4
      send_ar(4'd9, 32'h200, 8'd3, 3'd3, 2'd1, hs);
      expect_beat("rst_b0", 4'd9, 64'h00000200_00000200, 2'b00, 1'b0, t);
      #2;
      check("rst_mid_burst_rvalid", 72'(rvalid), 72'(1));
      rst = 1'b1;
      #1;
      check("rst_async_drop", {rvalid, rlast, rid, rdata, rresp}, 72'(0));
      tick(2);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rvalid) seen++;
      end
      check("rst_no_more_beats", 72'(seen), 72'(0));
      tick(1);
      send_ar(4'd10, 32'h300, 8'd1, 3'd3, 2'd1, hs);
      expect_beat("post_rst_b0", 4'd10, 64'h00000300_00000300, 2'b00, 1'b0, t);
      expect_beat("post_rst_b1", 4'd10, 64'h00000308_00000308, 2'b00, 1'b1, t);

      // Random traffic against the model
      rr_mode = 1;
      for (int i = 0; i < 60; i++) begin
         rid_r   = 4'($urandom);
         burst_r = 2'($urandom_range(0, 3));
         size_r  = 3'($urandom_range(0, 3));
         len_r   = (burst_r == 2'd2) ? wl[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
         r       = $urandom_range(0, 9);
         if (r < 6)      a_r = 32'($urandom_range(0, 32'hFFFF));
         else if (r < 8) a_r = 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
         else            a_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         send_ar(rid_r, a_r, len_r, size_r, burst_r, hs);
         tick($urandom_range(0, 3));
      end
      wait_drain("drain_random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
